// File: rtl/spi_reg_bridge.sv
// Purpose: SPI mode-0 slave that turns framed headers into register-bus writes/reads (burst, prefetch, dummy bits).
// Latency: SYNC_STAGES+1 clk pin-to-edge; strobe/request one clk after the detected rise ending a header or beat.
// Backpressure: none toward SPI; read requests are held until data_ready; a beat with no data is sent as 0 and flagged.
//
// Ports:
//   clk, rst_n                       system clock, synchronous active-low reset
//   spi_cs_n, spi_clk, spi_mosi      raw asynchronous SPI pins (mode 0)
//   spi_miso                         serial read data, 0 whenever CS is high
//   address, data_in                 register bus address / zero-extended write data
//   data_write_n, data_read_n        width-coded write strobe / read request, 2'b11 when idle
//   data_out, data_ready             peripheral read data and its valid
//   rd_overrun                       one-cycle pulse when a read beat starts before its data arrived
module spi_reg_bridge #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_BITS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_ready,
  output logic              rd_overrun
);

  localparam int H = 4 + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_RDUMMY,
    S_RDATA,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------- helpers
  function automatic logic [5:0] beat_bits(input logic [1:0] code);
    case (code)
      2'b00:   return 6'd8;
      2'b01:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic width_ok(input logic [1:0] code);
    return (code != 2'b11) && (int'(beat_bits(code)) <= DATA_W);
  endfunction

  function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] code);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(beat_bits(code)));
    return m;
  endfunction

  // Byte step per beat; truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [1:0] code);
    logic [ADDR_W+2:0] s;
    s       = '0;
    s[code] = 1'b1;
    return s[ADDR_W-1:0];
  endfunction

  // ---------------------------------------------------------- synchronizers
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall;

  // CS chain and cs_prev_q reset low so that, after a reset with CS still
  // asserted, no falling edge is seen until CS has gone high again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= SYNC_STAGES'({cs_sync_q, spi_cs_n});
      sck_sync_q  <= SYNC_STAGES'({sck_sync_q, spi_clk});
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi});
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_s;

  // ------------------------------------------------------------- registers
  state_t            state_q;
  logic [5:0]        bit_cnt_q;
  logic [H-2:0]      hdr_q;
  logic [1:0]        code_q;
  logic              burst_q;
  logic [ADDR_W-1:0] addr_q;        // address of the next write beat / next read request
  logic [DATA_W-2:0] wsh_q;
  logic [DATA_W-1:0] rsh_q;
  logic              beat_start_q;  // next falling edge begins a read beat
  logic              miso_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_in_q;
  logic [1:0]        data_write_n_q;
  logic [1:0]        data_read_n_q;
  logic              drop_q;        // data of the outstanding request is stale
  logic              req_want_q;    // a request is waiting for the bus to go idle
  logic [DATA_W-1:0] buf_q;
  logic              buf_vld_q;
  logic              rd_overrun_q;

  // ---------------------------------------------------------- decode paths
  logic [H-1:0]      hdr_full;
  logic              hdr_rw, hdr_burst;
  logic [1:0]        hdr_code;
  logic [ADDR_W-1:0] hdr_addr;
  logic [DATA_W-1:0] wr_raw, wr_word;
  logic              req_busy, rsp_take, rsp_keep, buf_avail;
  logic [DATA_W-1:0] rsp_word, buf_word, load_word, aligned;

  assign hdr_full  = {hdr_q, mosi_s};
  assign hdr_rw    = hdr_full[H-1];
  assign hdr_code  = hdr_full[H-2:H-3];
  assign hdr_burst = hdr_full[H-4];
  assign hdr_addr  = hdr_full[ADDR_W-1:0];

  assign wr_raw  = {wsh_q, mosi_s};
  assign wr_word = wr_raw & width_mask(code_q);

  assign req_busy = (data_read_n_q != 2'b11);
  assign rsp_take = req_busy & data_ready;
  assign rsp_keep = rsp_take & ~drop_q;
  assign rsp_word = data_out & width_mask(data_read_n_q);

  // Data arriving on the very cycle a beat starts is forwarded straight into
  // the shift register rather than counted as an overrun.
  assign buf_avail = buf_vld_q | rsp_keep;
  assign buf_word  = buf_vld_q ? buf_q : rsp_word;
  assign load_word = buf_avail ? buf_word : '0;
  // Left-align the beat so its MSB is always shifted out of bit DATA_W-1.
  assign aligned   = load_word << (DATA_W - int'(beat_bits(code_q)));

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      hdr_q          <= '0;
      code_q         <= 2'b11;
      burst_q        <= 1'b0;
      addr_q         <= '0;
      wsh_q          <= '0;
      rsh_q          <= '0;
      beat_start_q   <= 1'b0;
      miso_q         <= 1'b0;
      address_q      <= '0;
      data_in_q      <= '0;
      data_write_n_q <= 2'b11;
      data_read_n_q  <= 2'b11;
      drop_q         <= 1'b0;
      req_want_q     <= 1'b0;
      buf_q          <= '0;
      buf_vld_q      <= 1'b0;
      rd_overrun_q   <= 1'b0;
    end else begin
      data_write_n_q <= 2'b11;
      rd_overrun_q   <= 1'b0;

      // Read handshake completes on the first sampled data_ready.
      if (rsp_take) begin
        data_read_n_q <= 2'b11;
        drop_q        <= 1'b0;
        if (!drop_q) begin
          buf_q     <= rsp_word;
          buf_vld_q <= 1'b1;
        end
      end

      // Deferred request, issued once the previous handshake has finished.
      if (req_want_q && !req_busy && !cs_s) begin
        data_read_n_q <= code_q;
        address_q     <= addr_q;
        addr_q        <= addr_q + addr_step(code_q);
        req_want_q    <= 1'b0;
      end

      if (cs_s) begin
        state_q      <= S_IDLE;
        miso_q       <= 1'b0;
        buf_vld_q    <= 1'b0;
        req_want_q   <= 1'b0;
        beat_start_q <= 1'b0;
        if (req_busy && !data_ready) drop_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_fall) begin
              state_q   <= S_HDR;
              bit_cnt_q <= '0;
            end
          end

          S_HDR: begin
            if (sck_rise) begin
              hdr_q     <= hdr_full[H-2:0];
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'(H - 1)) begin
                code_q    <= hdr_code;
                burst_q   <= hdr_burst;
                bit_cnt_q <= '0;
                if (!width_ok(hdr_code)) begin
                  state_q <= S_DONE;
                end else if (hdr_rw) begin
                  state_q <= S_WDATA;
                  addr_q  <= hdr_addr;
                  wsh_q   <= '0;
                end else begin
                  state_q <= S_RDUMMY;
                  if (!req_busy && !req_want_q) begin
                    data_read_n_q <= hdr_code;
                    address_q     <= hdr_addr;
                    addr_q        <= hdr_addr + addr_step(hdr_code);
                  end else begin
                    addr_q     <= hdr_addr;
                    req_want_q <= 1'b1;
                  end
                end
              end
            end
          end

          S_WDATA: begin
            if (sck_rise) begin
              wsh_q     <= wr_raw[DATA_W-2:0];
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == beat_bits(code_q) - 6'd1) begin
                data_in_q      <= wr_word;
                address_q      <= addr_q;
                data_write_n_q <= code_q;
                addr_q         <= addr_q + addr_step(code_q);
                bit_cnt_q      <= '0;
                wsh_q          <= '0;
                if (!burst_q) state_q <= S_DONE;
              end
            end
          end

          S_RDUMMY: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'(DUMMY_BITS - 1)) begin
                state_q      <= S_RDATA;
                bit_cnt_q    <= '0;
                beat_start_q <= 1'b1;
              end
            end
          end

          S_RDATA: begin
            if (sck_fall) begin
              if (beat_start_q) begin
                beat_start_q <= 1'b0;
                miso_q       <= aligned[DATA_W-1];
                rsh_q        <= aligned << 1;
                buf_vld_q    <= 1'b0;
                if (!buf_avail) begin
                  rd_overrun_q <= 1'b1;
                  // The late data belongs to the beat just sent as zeros.
                  if (req_busy && !rsp_take) drop_q <= 1'b1;
                end
                if (burst_q) begin
                  if (!req_busy && !req_want_q) begin
                    data_read_n_q <= code_q;
                    address_q     <= addr_q;
                    addr_q        <= addr_q + addr_step(code_q);
                  end else begin
                    req_want_q <= 1'b1;
                  end
                end
              end else begin
                miso_q <= rsh_q[DATA_W-1];
                rsh_q  <= rsh_q << 1;
              end
            end
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == beat_bits(code_q) - 6'd1) begin
                bit_cnt_q <= '0;
                if (burst_q) beat_start_q <= 1'b1;
                else         state_q      <= S_DONE;
              end
            end
          end

          S_DONE: begin
            if (sck_fall) miso_q <= 1'b0;
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_miso     = miso_q & ~spi_cs_n;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign data_write_n = data_write_n_q;
  assign data_read_n  = data_read_n_q;
  assign rd_overrun   = rd_overrun_q;

endmodule
